// File: rtl/scan_sequencer.sv
// scan_sequencer: steps an N-bit select through the enabled positions of a
// 2**N-way group, holding each for a programmable dwell and inserting an
// optional dead-time between positions (break-before-make). x/en feed a
// one-hot decoder directly; every output comes straight from a flop.
//
// Interface behaviour: there is no valid/ready handshake. run is a level;
// mask is consumed only when a new position is chosen; div and blank are
// consumed only when the dwell or blank counter is loaded.
module scan_sequencer #(
  parameter int N     = 3,
  parameter int DIV_W = 16,
  parameter int BLK_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [DIV_W-1:0]    div,
  input  logic [BLK_W-1:0]    blank,
  input  logic [(2**N)-1:0]   mask,
  output logic [N-1:0]        x,
  output logic                en,
  output logic                wrap,
  output logic [1:0]          dbg_state
);

  localparam int POS = 2**N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [N-1:0]     x_n;
  logic             en_n;
  logic             wrap_n;
  logic [DIV_W-1:0] dcnt, dcnt_n;
  logic [BLK_W-1:0] bcnt, bcnt_n;

  logic [N-1:0]     low_idx;
  logic [N-1:0]     nxt_idx;
  logic [N-1:0]     cand;
  logic             advance;

  assign dbg_state = state;

  // Position search: lowest enabled bit (for start-up) and the first enabled
  // bit circularly above x (for advancing). Scanning from the far end down
  // lets the nearest hit overwrite earlier ones. A distance of POS wraps to
  // x itself, which covers the single-position case.
  always_comb begin
    low_idx = '0;
    for (int i = POS - 1; i >= 0; i--) begin
      if (mask[i]) low_idx = N'(i);
    end
    nxt_idx = x;
    cand    = x;
    for (int k = POS; k >= 1; k--) begin
      cand = x + N'(k);
      if (mask[cand]) nxt_idx = cand;
    end
  end

  // Next-state and registered-output logic for the IDLE/DWELL/BLANK FSM.
  always_comb begin
    state_n = state;
    x_n     = x;
    en_n    = 1'b0;
    wrap_n  = 1'b0;
    dcnt_n  = dcnt;
    bcnt_n  = bcnt;
    advance = 1'b0;

    case (state)
      IDLE: begin
        if (run && (|mask)) begin
          x_n     = low_idx;
          dcnt_n  = div;
          state_n = DWELL;
          en_n    = 1'b1;
        end
      end

      DWELL: begin
        en_n = 1'b1;
        if (!run) begin
          state_n = IDLE;
          en_n    = 1'b0;
        end else if (dcnt != '0) begin
          dcnt_n = dcnt - 1'b1;
        end else if (blank == '0) begin
          advance = 1'b1;
        end else begin
          // blank-1 because the transition cycle itself is not counted;
          // BLANK then lasts exactly 'blank' cycles.
          bcnt_n  = blank - 1'b1;
          state_n = BLANK;
          en_n    = 1'b0;
        end
      end

      BLANK: begin
        if (!run) begin
          state_n = IDLE;
        end else if (bcnt != '0) begin
          bcnt_n = bcnt - 1'b1;
        end else begin
          advance = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Common advance path from DWELL (no dead-time) or end of BLANK.
    // x and en change on the same edge, so en never rises on a stale x.
    if (advance) begin
      if (|mask) begin
        x_n     = nxt_idx;
        dcnt_n  = div;
        state_n = DWELL;
        en_n    = 1'b1;
        wrap_n  = (nxt_idx <= x);
      end else begin
        state_n = IDLE;
        en_n    = 1'b0;
      end
    end
  end

  // State, outputs and counters; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      en    <= 1'b0;
      wrap  <= 1'b0;
      dcnt  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      en    <= en_n;
      wrap  <= wrap_n;
      dcnt  <= dcnt_n;
      bcnt  <= bcnt_n;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer. Inputs are driven and outputs sampled
// on the falling edge, so each sample shows the result of the preceding
// rising edge and each drive is seen by the next rising edge.
module tb_scan_sequencer;

  localparam int N     = 3;
  localparam int DIV_W = 16;
  localparam int BLK_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  logic             clk;
  logic             reset;
  logic             run;
  logic [DIV_W-1:0] div;
  logic [BLK_W-1:0] blank;
  logic [7:0]       mask;
  logic [N-1:0]     x;
  logic             en;
  logic             wrap;
  logic [1:0]       dbg_state;

  int checks;
  int errors;

  scan_sequencer #(.N(N), .DIV_W(DIV_W), .BLK_W(BLK_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .div       (div),
    .blank     (blank),
    .mask      (mask),
    .x         (x),
    .en        (en),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // Clock and initial input values.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    div   = '0;
    blank = '0;
    mask  = '0;
  end

  // Driver: hold reset for two edges; leaves reset high at a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Driver: release reset and start scanning; first dwell follows next edge.
  task automatic start(input logic [7:0] m, input logic [DIV_W-1:0] d,
                       input logic [BLK_W-1:0] b);
    mask  = m;
    div   = d;
    blank = b;
    reset = 1'b0;
    run   = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (x !== 3'd0 || en !== 1'b0 || wrap !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset: x=%0d en=%0b wrap=%0b st=%0d, want x=0 en=0 wrap=0 st=0",
               x, en, wrap, dbg_state);
    end
  endtask

  // mask=FF div=1 blank=0: x = 0,0,1,1,...,7,7,0,0 with en always 1.
  task automatic test_full_scan();
    logic [2:0] ex;
    logic       ew;
    apply_reset();
    start(8'hFF, 16'd1, 4'd0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      ex = 3'((i / 2) % 8);
      ew = (i == 16);
      checks++;
      if (x !== ex || en !== 1'b1 || wrap !== ew || dbg_state !== S_DWELL) begin
        errors++;
        $display("FAIL full_scan c%0d: x=%0d en=%0b wrap=%0b st=%0d, want x=%0d en=1 wrap=%0b st=1",
                 i, x, en, wrap, dbg_state, ex, ew);
      end
    end
  endtask

  // mask=1010_0100 div=0 blank=2: positions 2,5,7 each 1 on + 2 off.
  task automatic test_sparse_blank();
    logic [2:0] seq [3];
    logic [2:0] ex;
    logic       ee;
    logic       ew;
    logic [1:0] es;
    seq[0] = 3'd2; seq[1] = 3'd5; seq[2] = 3'd7;
    apply_reset();
    start(8'b1010_0100, 16'd0, 4'd2);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      ex = seq[(i / 3) % 3];
      ee = ((i % 3) == 0);
      ew = (i > 0) && ((i % 9) == 0);
      es = ee ? S_DWELL : S_BLANK;
      checks++;
      if (x !== ex || en !== ee || wrap !== ew || dbg_state !== es) begin
        errors++;
        $display("FAIL sparse_blank c%0d: x=%0d en=%0b wrap=%0b st=%0d, want x=%0d en=%0b wrap=%0b st=%0d",
                 i, x, en, wrap, dbg_state, ex, ee, ew, es);
      end
    end
  endtask

  // mask=0001_0000 div=2 blank=1: x=4, en 1,1,1,0, wrap every 4 cycles.
  task automatic test_single_pos();
    logic ee;
    logic ew;
    apply_reset();
    start(8'h10, 16'd2, 4'd1);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ee = ((i % 4) != 3);
      ew = (i > 0) && ((i % 4) == 0);
      checks++;
      if (x !== 3'd4 || en !== ee || wrap !== ew) begin
        errors++;
        $display("FAIL single_pos c%0d: x=%0d en=%0b wrap=%0b, want x=4 en=%0b wrap=%0b",
                 i, x, en, wrap, ee, ew);
      end
    end
  endtask

  // Single position, no dwell extension, no blank: wrap every cycle after entry.
  task automatic test_back_to_back();
    logic ew;
    apply_reset();
    start(8'h01, 16'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ew = (i > 0);
      checks++;
      if (x !== 3'd0 || en !== 1'b1 || wrap !== ew) begin
        errors++;
        $display("FAIL back_to_back c%0d: x=%0d en=%0b wrap=%0b, want x=0 en=1 wrap=%0b",
                 i, x, en, wrap, ew);
      end
    end
  endtask

  // Drop run on position 6, hold, then restart at lowest enabled (5).
  task automatic test_run_stop();
    apply_reset();
    start(8'b0110_0000, 16'd0, 4'd0);
    @(negedge clk);
    checks++;
    if (x !== 3'd5 || en !== 1'b1) begin
      errors++;
      $display("FAIL run_stop first: x=%0d en=%0b, want x=5 en=1", x, en);
    end
    @(negedge clk);
    checks++;
    if (x !== 3'd6 || en !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL run_stop second: x=%0d en=%0b wrap=%0b, want x=6 en=1 wrap=0", x, en, wrap);
    end
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (x !== 3'd6 || en !== 1'b0 || wrap !== 1'b0 || dbg_state !== S_IDLE) begin
        errors++;
        $display("FAIL run_stop hold c%0d: x=%0d en=%0b wrap=%0b st=%0d, want x=6 en=0 wrap=0 st=0",
                 i, x, en, wrap, dbg_state);
      end
    end
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (x !== 3'd5 || en !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL run_stop restart: x=%0d en=%0b wrap=%0b, want x=5 en=1 wrap=0", x, en, wrap);
    end
  endtask

  // mask cleared mid-dwell: dwell and blank finish, then IDLE; restore mask.
  task automatic test_mask_clear();
    logic       ee;
    logic [1:0] es;
    apply_reset();
    start(8'b0000_1010, 16'd2, 4'd1);
    @(negedge clk);
    checks++;
    if (x !== 3'd1 || en !== 1'b1) begin
      errors++;
      $display("FAIL mask_clear first: x=%0d en=%0b, want x=1 en=1", x, en);
    end
    mask = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      ee = (i <= 2);
      es = (i <= 2) ? S_DWELL : ((i == 3) ? S_BLANK : S_IDLE);
      checks++;
      if (x !== 3'd1 || en !== ee || wrap !== 1'b0 || dbg_state !== es) begin
        errors++;
        $display("FAIL mask_clear c%0d: x=%0d en=%0b wrap=%0b st=%0d, want x=1 en=%0b wrap=0 st=%0d",
                 i, x, en, wrap, dbg_state, ee, es);
      end
    end
    mask = 8'b0000_1000;
    @(negedge clk);
    checks++;
    if (x !== 3'd3 || en !== 1'b1 || wrap !== 1'b0 || dbg_state !== S_DWELL) begin
      errors++;
      $display("FAIL mask_clear resume: x=%0d en=%0b wrap=%0b st=%0d, want x=3 en=1 wrap=0 st=1",
               x, en, wrap, dbg_state);
    end
  endtask

  // Reset asserted mid-BLANK, then mid-DWELL; restart one cycle after release.
  task automatic test_reset_mid();
    apply_reset();
    start(8'b1010_0100, 16'd0, 4'd2);
    repeat (2) @(negedge clk);
    checks++;
    if (x !== 3'd2 || en !== 1'b0 || dbg_state !== S_BLANK) begin
      errors++;
      $display("FAIL reset_mid blank_pre: x=%0d en=%0b st=%0d, want x=2 en=0 st=2", x, en, dbg_state);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (x !== 3'd0 || en !== 1'b0 || wrap !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_mid blank: x=%0d en=%0b wrap=%0b st=%0d, want x=0 en=0 wrap=0 st=0",
               x, en, wrap, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (x !== 3'd2 || en !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid blank_restart: x=%0d en=%0b wrap=%0b, want x=2 en=1 wrap=0", x, en, wrap);
    end

    apply_reset();
    start(8'hA0, 16'd3, 4'd2);
    repeat (2) @(negedge clk);
    checks++;
    if (x !== 3'd5 || en !== 1'b1 || dbg_state !== S_DWELL) begin
      errors++;
      $display("FAIL reset_mid dwell_pre: x=%0d en=%0b st=%0d, want x=5 en=1 st=1", x, en, dbg_state);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (x !== 3'd0 || en !== 1'b0 || wrap !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_mid dwell: x=%0d en=%0b wrap=%0b st=%0d, want x=0 en=0 wrap=0 st=0",
               x, en, wrap, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (x !== 3'd5 || en !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid dwell_restart: x=%0d en=%0b wrap=%0b, want x=5 en=1 wrap=0", x, en, wrap);
    end
  endtask

  // Sequence of scenarios and final report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_scan();
    test_sparse_blank();
    test_single_pos();
    test_back_to_back();
    test_run_stop();
    test_mask_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
